ikaopll_acc_mixer: RTL and testbench

//  Parametrised multi-group accumulation DAC: successor to the fixed MO/RO 16-bit accumulator.

---
 rtl/ikaopll_acc_mixer.sv | 221 ++++++++++++++++++++++
 tb/tb_ikaopll_acc_mixer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ikaopll_acc_mixer.sv
// ikaopll_acc_mixer
//   Multi-group accumulation DAC. Each slot's sign-magnitude operator sample is converted to
//   two's complement, scaled by a signed per-group volume and summed into its group's
//   accumulator. At every frame boundary the accumulators are presented on o_MIX through a
//   valid/ready handshake, together with per-group clip status.
//
// Ports
//   i_EMUCLK       master clock
//   i_RST          asynchronous reset, active-high
//   i_phi1_NCEN_n  tick enable, active-low; frame and accumulate logic advance only on ticks
//   i_FRAME_START  cycle-0 marker, one tick wide
//   i_SAMPLE_EN    current slot carries a valid sample
//   i_GROUP_SEL    destination group of the current slot
//   i_OPDATA       sign-magnitude sample, MSB is the sign
//   i_VOL          signed volume per group, group g at [g*VOL_WIDTH +: VOL_WIDTH]
//   o_MIX          signed frame mix per group, group g at [g*OUT_WIDTH +: OUT_WIDTH]
//   o_CLIP         group overflowed during the frame now on o_MIX
//   o_VALID        o_MIX holds an unconsumed frame
//   i_READY        consumer accepts o_MIX
//   o_OVERRUN      sticky: a frame was dropped because o_MIX was not consumed
//   i_CLR_FLAGS    clears o_OVERRUN (a simultaneous overrun wins)
module ikaopll_acc_mixer #(
    parameter int OP_WIDTH   = 9,
    parameter int VOL_WIDTH  = 4,
    parameter int ACC_WIDTH  = 16,
    parameter int OUT_WIDTH  = 16,
    parameter int NUM_GROUPS = 2,
    parameter int FRAME_DLY  = 3,
    parameter int SATURATE   = 1,
    localparam int GSEL_W    = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1
) (
    input  logic                            i_EMUCLK,
    input  logic                            i_RST,
    input  logic                            i_phi1_NCEN_n,
    input  logic                            i_FRAME_START,
    input  logic                            i_SAMPLE_EN,
    input  logic [GSEL_W-1:0]               i_GROUP_SEL,
    input  logic [OP_WIDTH-1:0]             i_OPDATA,
    input  logic [NUM_GROUPS*VOL_WIDTH-1:0] i_VOL,
    output logic [NUM_GROUPS*OUT_WIDTH-1:0] o_MIX,
    output logic [NUM_GROUPS-1:0]           o_CLIP,
    output logic                            o_VALID,
    input  logic                            i_READY,
    output logic                            o_OVERRUN,
    input  logic                            i_CLR_FLAGS
);

    localparam int PROD_W = OP_WIDTH + VOL_WIDTH;
    localparam int SUM_W  = ACC_WIDTH + 1;
    localparam int SHIFT  = ACC_WIDTH - OUT_WIDTH;

    logic tick;
    assign tick = ~i_phi1_NCEN_n;

    // ---------------------------------------------------------------- stage 1: capture/convert
    logic [OP_WIDTH-1:0] op_conv;
    logic [OP_WIDTH-1:0] s1_v_q;
    logic [GSEL_W-1:0]   s1_sel_q;
    logic                s1_en_q;

    // Negative samples map to -mag-1, so +0 and -0 stay distinct rather than collapsing.
    assign op_conv = i_OPDATA[OP_WIDTH-1] ? {1'b1, ~i_OPDATA[OP_WIDTH-2:0]}
                                          : {1'b0, i_OPDATA[OP_WIDTH-2:0]};

    // ---------------------------------------------------------------- stage 2: volume scale
    logic [VOL_WIDTH-1:0]     vol_sel;
    logic signed [PROD_W-1:0] v_ext;
    logic signed [PROD_W-1:0] vol_ext;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] s2_p_q;
    logic [GSEL_W-1:0]        s2_sel_q;
    logic                     s2_en_q;

    always_comb begin
        vol_sel = '0;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            if (int'(s1_sel_q) == g) begin
                vol_sel = i_VOL[g*VOL_WIDTH +: VOL_WIDTH];
            end
        end
    end

    assign v_ext   = {{VOL_WIDTH{s1_v_q[OP_WIDTH-1]}}, s1_v_q};
    assign vol_ext = {{OP_WIDTH{vol_sel[VOL_WIDTH-1]}}, vol_sel};
    assign prod    = v_ext * vol_ext;

    always_ff @(posedge i_EMUCLK or posedge i_RST) begin
        if (i_RST) begin
            s1_v_q   <= '0;
            s1_sel_q <= '0;
            s1_en_q  <= 1'b0;
            s2_p_q   <= '0;
            s2_sel_q <= '0;
            s2_en_q  <= 1'b0;
        end else if (tick) begin
            s1_v_q   <= op_conv;
            s1_sel_q <= i_GROUP_SEL;
            s1_en_q  <= i_SAMPLE_EN;
            s2_p_q   <= prod;
            s2_sel_q <= s1_sel_q;
            s2_en_q  <= s1_en_q;
        end
    end

    // ---------------------------------------------------------------- frame boundary delay
    logic [FRAME_DLY-1:0] dly_q;
    logic [FRAME_DLY:0]   dly_sh;
    logic                 boundary;

    assign dly_sh   = {dly_q, i_FRAME_START};
    assign boundary = tick & dly_q[FRAME_DLY-1];

    always_ff @(posedge i_EMUCLK or posedge i_RST) begin
        if (i_RST) begin
            dly_q <= '0;
        end else if (tick) begin
            dly_q <= dly_sh[FRAME_DLY-1:0];
        end
    end

    // ---------------------------------------------------------------- accumulators
    logic signed [SUM_W-1:0]              p_ext;
    logic [NUM_GROUPS-1:0][ACC_WIDTH-1:0] acc_q;
    logic [NUM_GROUPS-1:0][ACC_WIDTH-1:0] acc_d;
    logic [NUM_GROUPS-1:0][ACC_WIDTH-1:0] acc_sat;
    logic [NUM_GROUPS-1:0][SUM_W-1:0]     sum;
    logic [NUM_GROUPS-1:0]                ovf;
    logic [NUM_GROUPS-1:0]                hit;
    logic [NUM_GROUPS-1:0]                clip_pend_q;
    logic [NUM_GROUPS-1:0]                clip_pend_d;

    assign p_ext = SUM_W'(s2_p_q);

    always_comb begin
        hit     = '0;
        sum     = '0;
        ovf     = '0;
        acc_sat = '0;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            hit[g] = s2_en_q && (int'(s2_sel_q) == g);
            sum[g] = SUM_W'($signed(acc_q[g])) + p_ext;
            // Overflow when the extra sum bit disagrees with the accumulator sign bit.
            ovf[g] = sum[g][SUM_W-1] ^ sum[g][SUM_W-2];
            if (ovf[g] && (SATURATE != 0)) begin
                acc_sat[g] = sum[g][SUM_W-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                             : {1'b0, {(ACC_WIDTH-1){1'b1}}};
            end else begin
                acc_sat[g] = sum[g][ACC_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        acc_d       = acc_q;
        clip_pend_d = clip_pend_q;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            if (boundary) begin
                // The boundary slot's sample seeds the next frame.
                acc_d[g]       = hit[g] ? p_ext[ACC_WIDTH-1:0] : '0;
                clip_pend_d[g] = 1'b0;
            end else if (hit[g]) begin
                acc_d[g]       = acc_sat[g];
                clip_pend_d[g] = clip_pend_q[g] | ovf[g];
            end
        end
    end

    always_ff @(posedge i_EMUCLK or posedge i_RST) begin
        if (i_RST) begin
            acc_q       <= '0;
            clip_pend_q <= '0;
        end else if (tick) begin
            acc_q       <= acc_d;
            clip_pend_q <= clip_pend_d;
        end
    end

    // ---------------------------------------------------------------- output handshake
    logic [NUM_GROUPS-1:0][ACC_WIDTH-1:0] acc_shr;
    logic [NUM_GROUPS*OUT_WIDTH-1:0]      out_cand;
    logic                                 accept;
    logic                                 out_free;
    logic                                 load;

    always_comb begin
        acc_shr  = '0;
        out_cand = '0;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            acc_shr[g] = $signed(acc_q[g]) >>> SHIFT;
            out_cand[g*OUT_WIDTH +: OUT_WIDTH] = acc_shr[g][OUT_WIDTH-1:0];
        end
    end

    assign accept   = o_VALID & i_READY;
    assign out_free = ~o_VALID | i_READY;
    assign load     = boundary & out_free;

    always_ff @(posedge i_EMUCLK or posedge i_RST) begin
        if (i_RST) begin
            o_MIX     <= '0;
            o_CLIP    <= '0;
            o_VALID   <= 1'b0;
            o_OVERRUN <= 1'b0;
        end else begin
            if (load) begin
                o_MIX   <= out_cand;
                o_CLIP  <= clip_pend_q;
                o_VALID <= 1'b1;
            end else if (accept) begin
                o_VALID <= 1'b0;
            end

            if (boundary && !out_free) begin
                o_OVERRUN <= 1'b1;
            end else if (i_CLR_FLAGS) begin
                o_OVERRUN <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ikaopll_acc_mixer.sv
// Directed bench for ikaopll_acc_mixer. Two instances share stimulus:
//   u_dut_a : defaults (2 groups, 16-bit out, saturating)
//   u_dut_b : 4 groups, 12-bit out (>>>4), wrapping
module tb_ikaopll_acc_mixer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ncen_n = 1'b1;
    logic        frame_start = 1'b0;
    logic        sample_en = 1'b0;
    logic        sel_a = 1'b0;
    logic [1:0]  sel_b = 2'd0;
    logic [8:0]  opdata = 9'd0;
    logic [7:0]  vol_a = 8'd0;
    logic [15:0] vol_b = 16'd0;
    logic        ready = 1'b1;
    logic        clr = 1'b0;

    logic [31:0] mix_a;
    logic [1:0]  clip_a;
    logic        valid_a;
    logic        overrun_a;
    logic [47:0] mix_b;
    logic [3:0]  clip_b;
    logic        valid_b;
    logic        overrun_b;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ikaopll_acc_mixer u_dut_a (
        .i_EMUCLK      (clk),
        .i_RST         (rst),
        .i_phi1_NCEN_n (ncen_n),
        .i_FRAME_START (frame_start),
        .i_SAMPLE_EN   (sample_en),
        .i_GROUP_SEL   (sel_a),
        .i_OPDATA      (opdata),
        .i_VOL         (vol_a),
        .o_MIX         (mix_a),
        .o_CLIP        (clip_a),
        .o_VALID       (valid_a),
        .i_READY       (ready),
        .o_OVERRUN     (overrun_a),
        .i_CLR_FLAGS   (clr)
    );

    ikaopll_acc_mixer #(
        .NUM_GROUPS (4),
        .OUT_WIDTH  (12),
        .SATURATE   (0)
    ) u_dut_b (
        .i_EMUCLK      (clk),
        .i_RST         (rst),
        .i_phi1_NCEN_n (ncen_n),
        .i_FRAME_START (frame_start),
        .i_SAMPLE_EN   (sample_en),
        .i_GROUP_SEL   (sel_b),
        .i_OPDATA      (opdata),
        .i_VOL         (vol_b),
        .o_MIX         (mix_b),
        .o_CLIP        (clip_b),
        .o_VALID       (valid_b),
        .i_READY       (ready),
        .o_OVERRUN     (overrun_b),
        .i_CLR_FLAGS   (clr)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One ticked slot; outputs are sampled 1 time unit after the edge.
    task automatic slot(input logic en, input int sel, input logic [8:0] data, input logic fs);
        ncen_n      = 1'b0;
        sample_en   = en;
        sel_a       = 1'(sel);
        sel_b       = 2'(sel);
        opdata      = data;
        frame_start = fs;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        sample_en   = 1'b0;
    endtask

    task automatic idle();
        ncen_n = 1'b1;
        @(posedge clk);
        #1;
        ncen_n = 1'b0;
    endtask

    // Frame marker slot, then three slots so the boundary edge (marker + 3 ticks) has just passed.
    task automatic close_frame();
        slot(1'b0, 0, 9'h000, 1'b1);
        repeat (3) slot(1'b0, 0, 9'h000, 1'b0);
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mix_a", $signed(mix_a), 0);
        chk("rst_valid_a", valid_a, 0);
        chk("rst_clip_a", clip_a, 0);
        chk("rst_overrun_a", overrun_a, 0);
        chk("rst_mix_b_g0", $signed(mix_b[11:0]), 0);
        chk("rst_valid_b", valid_b, 0);
        rst = 1'b0;

        // 1: three samples of +5 at volume 1
        vol_a = 8'h01;
        vol_b = 16'h0001;
        repeat (3) slot(1'b1, 0, 9'h005, 1'b0);
        close_frame();
        chk("t1_mix_a_g0", $signed(mix_a[15:0]), 15);
        chk("t1_valid_a", valid_a, 1);
        chk("t1_clip_a", clip_a, 0);
        chk("t1_mix_b_g0", $signed(mix_b[11:0]), 0);
        slot(1'b0, 0, 9'h000, 1'b0);
        chk("t1_valid_a_drop", valid_a, 0);

        // 2: negative volume on group 1
        vol_a = 8'h81;
        vol_b = 16'h0081;
        slot(1'b1, 1, 9'h1FF, 1'b0);
        close_frame();
        chk("t2a_mix_a_g1", $signed(mix_a[31:16]), 2048);
        chk("t2a_mix_a_g0", $signed(mix_a[15:0]), 0);
        chk("t2a_mix_b_g1", $signed(mix_b[23:12]), 128);
        slot(1'b1, 1, 9'h0FF, 1'b0);
        close_frame();
        chk("t2b_mix_a_g1", $signed(mix_a[31:16]), -2040);
        chk("t2b_mix_b_g1", $signed(mix_b[23:12]), -128);

        // 3: overflow, saturate (a) versus wrap (b)
        vol_a = 8'h07;
        vol_b = 16'h0007;
        repeat (19) slot(1'b1, 0, 9'h0FF, 1'b0);
        close_frame();
        chk("t3_mix_a_sat", $signed(mix_a[15:0]), 32767);
        chk("t3_clip_a", clip_a, 1);
        chk("t3_mix_b_wrap", $signed(mix_b[11:0]), -1977);
        chk("t3_clip_b", clip_b, 1);
        slot(1'b0, 0, 9'h000, 1'b0);
        chk("t3_valid_a_drop", valid_a, 0);

        // 4: back-pressure and overrun
        vol_a = 8'h01;
        vol_b = 16'h0001;
        ready = 1'b0;
        slot(1'b1, 0, 9'h002, 1'b0);
        close_frame();
        chk("t4_f1_mix_a", $signed(mix_a[15:0]), 2);
        chk("t4_f1_clip_a", clip_a, 0);
        chk("t4_f1_overrun", overrun_a, 0);
        slot(1'b1, 0, 9'h003, 1'b0);
        close_frame();
        chk("t4_f2_held_mix", $signed(mix_a[15:0]), 2);
        chk("t4_f2_valid", valid_a, 1);
        chk("t4_f2_overrun", overrun_a, 1);
        chk("t4_f2_overrun_b", overrun_b, 1);
        clr = 1'b1;
        slot(1'b0, 0, 9'h000, 1'b0);
        clr = 1'b0;
        chk("t4_clr_overrun", overrun_a, 0);
        slot(1'b1, 0, 9'h004, 1'b0);
        slot(1'b0, 0, 9'h000, 1'b1);
        repeat (2) slot(1'b0, 0, 9'h000, 1'b0);
        ready = 1'b1;
        slot(1'b0, 0, 9'h000, 1'b0);
        chk("t4_f3_mix", $signed(mix_a[15:0]), 4);
        chk("t4_f3_valid", valid_a, 1);
        chk("t4_f3_no_overrun", overrun_a, 0);
        slot(1'b0, 0, 9'h000, 1'b0);
        chk("t4_f3_valid_drop", valid_a, 0);

        // 5: boundary-slot sample goes to the next frame; idle and en=0 slots hold
        slot(1'b1, 0, 9'h010, 1'b0);
        idle();
        idle();
        slot(1'b0, 0, 9'h1FF, 1'b0);
        slot(1'b0, 0, 9'h000, 1'b1);
        slot(1'b1, 0, 9'h003, 1'b0);
        repeat (2) slot(1'b0, 0, 9'h000, 1'b0);
        chk("t5_cur_frame", $signed(mix_a[15:0]), 16);
        idle();
        chk("t5_accept_on_idle", valid_a, 0);
        close_frame();
        chk("t5_next_frame", $signed(mix_a[15:0]), 3);
        slot(1'b0, 0, 9'h000, 1'b0);

        // 6: reset mid-frame
        vol_a = 8'h11;
        vol_b = 16'h1001;
        ready = 1'b0;
        slot(1'b1, 3, 9'h020, 1'b0);
        close_frame();
        chk("t6_pre_mix_a_g1", $signed(mix_a[31:16]), 32);
        chk("t6_pre_mix_b_g3", $signed(mix_b[47:36]), 2);
        close_frame();
        chk("t6_pre_overrun", overrun_a, 1);
        repeat (2) slot(1'b1, 3, 9'h040, 1'b0);
        rst = 1'b1;
        #1;
        chk("t6_rst_mix_a", $signed(mix_a), 0);
        chk("t6_rst_valid_a", valid_a, 0);
        chk("t6_rst_overrun_a", overrun_a, 0);
        chk("t6_rst_mix_b_g3", $signed(mix_b[47:36]), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ready = 1'b1;
        slot(1'b1, 3, 9'h050, 1'b0);
        slot(1'b1, 3, 9'h108, 1'b0);
        close_frame();
        chk("t6_post_mix_a_g1", $signed(mix_a[31:16]), 71);
        chk("t6_post_mix_a_g0", $signed(mix_a[15:0]), 0);
        chk("t6_post_mix_b_g3", $signed(mix_b[47:36]), 4);
        chk("t6_post_valid_b", valid_b, 1);
        chk("t6_post_overrun_a", overrun_a, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
